sram_seq: RTL and testbench
===========================

SRAM_SEQ -- requirements
Module: sram_seq

Interface
REQ-001 Parameter ROWS, default 16: number of word rows in the array; minimum 2, need not be a power of two.
REQ-002 Parameter COLS, default 8: bits per word; minimum 2.
REQ-003 Parameter WR_CYC, default 2: cycles the write wordline enable is held; minimum 1.
REQ-004 Parameter RD_SETTLE, default 3: cycles the read wordline is held before sense data is captured; minimum 1.
REQ-005 Parameter MAX_BURST, default 4: maximum words per command; minimum 1.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 arst  in  1  reset; asynchronous, active-high.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-010 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-011 cmd_addr  in  clog2(ROWS)  start row.
REQ-012 cmd_len  in  clog2(MAX_BURST)+1  word count minus one.
REQ-013 ser_in  in  1  serial write data, LSB first, sampled every SHIFT_IN cycle.
REQ-014 row_sel  out  clog2(ROWS)  row address to both decoders.
REQ-015 wl_wr_en, wl_rd_en  out  1 each  write and read wordline enables.
REQ-016 col_data  out  COLS  parallel word to the write driver DAC.
REQ-017 sa_data  in  COLS  digitised sense-amplifier outputs.
REQ-018 ser_out, ser_out_valid  out  1 each  serial read data, LSB first, with its qualifier.
REQ-019 done, err  out  1 each  one-cycle completion pulse and its error flag.

Function
REQ-020 States: IDLE, SHIFT_IN, WRITE, READ, SHIFT_OUT, NEXT.
REQ-021 On an accepted command, latch cmd_addr, cmd_len and cmd_write; go to SHIFT_IN if writing, otherwise READ.
REQ-022 If cmd_addr >= ROWS or cmd_len >= MAX_BURST: stay in IDLE and, on the cycle after acceptance, pulse done=1 and err=1; no wordline asserts.
REQ-023 SHIFT_IN lasts exactly COLS cycles; bit k of the word is the ser_in sample in SHIFT_IN cycle k; col_data updates only when the full word is complete, at entry to WRITE.
REQ-024 WRITE holds wl_wr_en=1 for exactly WR_CYC cycles with row_sel stable, then goes to NEXT.
REQ-025 READ holds wl_rd_en=1 for exactly RD_SETTLE cycles and captures sa_data on its last cycle; then goes to SHIFT_OUT.
REQ-026 SHIFT_OUT lasts exactly COLS cycles with ser_out_valid=1; ser_out presents the captured bit k in cycle k; then goes to NEXT.
REQ-027 NEXT lasts one cycle and then branches:
- remaining words: row_sel increments, wrapping from ROWS-1 to 0, and the sequence re-enters SHIFT_IN or READ;
- otherwise: pulse done=1 with err=0 and return to IDLE.
REQ-028 wl_wr_en and wl_rd_en are never high in the same cycle.
REQ-029 row_sel changes only in NEXT or IDLE.
REQ-030 cmd_valid is ignored outside IDLE.
REQ-031 Single-word write latency from acceptance to done is COLS+WR_CYC+1 cycles; single-word read latency is RD_SETTLE+COLS+1 cycles.

Reset
REQ-032 While arst is high the state is IDLE, and every output is 0 except cmd_ready, which is 1.
REQ-033 All counters and data registers are cleared by reset.
REQ-034 Reset asserted mid-burst aborts the burst immediately; no done pulse is issued for it, and wordlines drop asynchronously.

Structure
REQ-035 The state enum and the default parameter constants live in a shared package sram_pkg.
REQ-036 The serial shift registers are a single sub-module, sram_shreg (COLS wide, with load, shift and parallel in/out), instantiated once for SHIFT_IN and once for SHIFT_OUT.

Verification
REQ-037 Defaults; write at addr 3, len 0, ser_in bits 1,0,1,1,0,0,1,0:
- col_data=8'h4D at entry to WRITE;
- wl_wr_en high for 2 cycles with row_sel=3;
- done at cycle 11 after acceptance.
REQ-038 Read at addr 3 with sa_data=8'hA5:
- wl_rd_en high for 3 cycles;
- ser_out sequence 1,0,1,0,0,1,0,1;
- done at cycle 12.
REQ-039 Write burst, addr 15, len 2: row_sel sequence is 15, 0, 1 and 3 WRITE phases occur.
REQ-040 Invalid commands: addr 16, or len 4, produce done=1 and err=1 one cycle after acceptance, with no wordline activity.
REQ-041 arst pulsed during the 2nd READ cycle: wl_rd_en drops the same cycle, cmd_ready=1, no done pulse, and the next command executes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM row sequencer: sequencer states and the
// default array geometry / timing constants.
package sram_pkg;

  localparam int DEF_ROWS      = 16;
  localparam int DEF_COLS      = 8;
  localparam int DEF_WR_CYC    = 2;
  localparam int DEF_RD_SETTLE = 3;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WRITE,
    READ,
    SHIFT_OUT,
    NEXT
  } state_t;

endpackage

// File: rtl/sram_shreg.sv
// COLS-wide shift register with parallel load. Shifts toward bit 0, so a
// serial stream entering at the MSB ends up LSB-first, and ser_out always
// presents bit 0.
module sram_shreg
  import sram_pkg::*;
#(
  parameter int COLS = DEF_COLS
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            load,
  input  logic            shift,
  input  logic            ser_in,
  input  logic [COLS-1:0] par_in,
  output logic [COLS-1:0] par_out,
  output logic            ser_out
);

  logic [COLS-1:0] word_q;

  // Parallel load wins over shifting; shifting moves every bit one place toward the LSB.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= par_in;
    end else if (shift) begin
      word_q <= {ser_in, word_q[COLS-1:1]};
    end
  end

  assign par_out = word_q;
  assign ser_out = word_q[0];

endmodule

// File: rtl/sram_seq.sv
// SRAM row sequencer: accepts burst commands, deserialises write words and
// drives the write wordline, or pulses the read wordline, captures the sense
// amplifiers and serialises the word back out, stepping through rows with wrap.
module sram_seq
  import sram_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int WR_CYC    = DEF_WR_CYC,
  parameter int RD_SETTLE = DEF_RD_SETTLE,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [$clog2(ROWS)-1:0]    cmd_addr,
  input  logic [$clog2(MAX_BURST):0] cmd_len,
  input  logic                       ser_in,
  output logic [$clog2(ROWS)-1:0]    row_sel,
  output logic                       wl_wr_en,
  output logic                       wl_rd_en,
  output logic [COLS-1:0]            col_data,
  input  logic [COLS-1:0]            sa_data,
  output logic                       ser_out,
  output logic                       ser_out_valid,
  output logic                       done,
  output logic                       err
);

  localparam int ADDR_W  = $clog2(ROWS);
  localparam int LEN_W   = $clog2(MAX_BURST) + 1;
  localparam int CNT_MAX = (COLS > WR_CYC) ? ((COLS > RD_SETTLE) ? COLS : RD_SETTLE)
                                           : ((WR_CYC > RD_SETTLE) ? WR_CYC : RD_SETTLE);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  phase_cnt;
  logic [LEN_W-1:0]  words_left;
  logic              is_write;
  logic [ADDR_W-1:0] row_q;
  logic [COLS-1:0]   col_q;
  logic              err_pulse;
  logic              accept;
  logic              cmd_bad;
  logic              phase_last;
  logic [COLS-1:0]   in_word;
  logic [COLS-1:0]   out_word;
  logic              in_ser;
  logic              out_ser;
  logic              unused_taps;

  assign accept  = cmd_valid && (state == IDLE);
  assign cmd_bad = (32'(cmd_addr) >= 32'(ROWS)) || (32'(cmd_len) >= 32'(MAX_BURST));

  // Next-state and Moore outputs; each timed phase ends when its cycle counter hits the phase length.
  always_comb begin
    state_n       = state;
    phase_last    = 1'b0;
    cmd_ready     = 1'b0;
    wl_wr_en      = 1'b0;
    wl_rd_en      = 1'b0;
    ser_out_valid = 1'b0;
    done          = err_pulse;
    err           = err_pulse;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept && !cmd_bad) begin
          state_n = cmd_write ? SHIFT_IN : READ;
        end
      end
      SHIFT_IN: begin
        phase_last = (phase_cnt == CNT_W'(COLS - 1));
        if (phase_last) state_n = WRITE;
      end
      WRITE: begin
        wl_wr_en   = 1'b1;
        phase_last = (phase_cnt == CNT_W'(WR_CYC - 1));
        if (phase_last) state_n = NEXT;
      end
      READ: begin
        wl_rd_en   = 1'b1;
        phase_last = (phase_cnt == CNT_W'(RD_SETTLE - 1));
        if (phase_last) state_n = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        ser_out_valid = 1'b1;
        phase_last    = (phase_cnt == CNT_W'(COLS - 1));
        if (phase_last) state_n = NEXT;
      end
      NEXT: begin
        if (words_left == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = is_write ? SHIFT_IN : READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset drops straight back to IDLE so wordlines fall immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_n;
  end

  // Cycle counter within the current phase, restarted on every state change.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      phase_cnt <= '0;
    end else if ((state_n != state) || (state == IDLE)) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Command latching, burst bookkeeping with row wrap, error pulse, and write-word capture.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      row_q      <= '0;
      words_left <= '0;
      is_write   <= 1'b0;
      err_pulse  <= 1'b0;
      col_q      <= '0;
    end else begin
      err_pulse <= accept && cmd_bad;
      if (accept && !cmd_bad) begin
        row_q      <= cmd_addr;
        words_left <= cmd_len;
        is_write   <= cmd_write;
      end else if ((state == NEXT) && (words_left != '0)) begin
        words_left <= words_left - 1'b1;
        row_q      <= (row_q == ADDR_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end
      if ((state == SHIFT_IN) && phase_last) begin
        col_q <= {ser_in, in_word[COLS-1:1]};
      end
    end
  end

  sram_shreg #(.COLS(COLS)) u_shift_in (
    .clk     (clk),
    .arst    (arst),
    .load    (1'b0),
    .shift   (state == SHIFT_IN),
    .ser_in  (ser_in),
    .par_in  ('0),
    .par_out (in_word),
    .ser_out (in_ser)
  );

  sram_shreg #(.COLS(COLS)) u_shift_out (
    .clk     (clk),
    .arst    (arst),
    .load    ((state == READ) && phase_last),
    .shift   (state == SHIFT_OUT),
    .ser_in  (1'b0),
    .par_in  (sa_data),
    .par_out (out_word),
    .ser_out (out_ser)
  );

  // Taps of the shared shift-register cell that neither direction needs.
  assign unused_taps = ^{in_word[0], in_ser, out_word};

  assign ser_out  = out_ser & ser_out_valid;
  assign row_sel  = row_q;
  assign col_data = col_q;

endmodule

// File: tb/tb_sram_seq.sv
// Self-checking bench for sram_seq: a cycle-timeline model built from the
// command rules is compared against the DUT every cycle, with literal pins
// on the headline latencies and data values.
module tb_sram_seq;

  localparam int ROWS      = 16;
  localparam int COLS      = 8;
  localparam int WR_CYC    = 2;
  localparam int RD_SETTLE = 3;
  localparam int MAX_BURST = 4;

  logic       clk;
  logic       arst;
  logic       cmd_valid;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       ser_in;
  logic [7:0] sa_data;

  logic       cmd_ready, wl_wr_en, wl_rd_en, ser_out, ser_out_valid, done, err;
  logic [3:0] row_sel;
  logic [7:0] col_data;

  logic       b_cmd_ready, b_wl_wr_en, b_wl_rd_en, b_ser_out, b_ser_out_valid, b_done, b_err;
  logic [3:0] b_row_sel;
  logic [7:0] b_col_data;

  typedef struct packed {
    logic       ready, wr, rd, sv, so, dn, er;
    logic [3:0] row;
    logic [7:0] col;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_row;
  logic [7:0] m_col;

  int n_checks;
  int n_errors;

  int         since_acc, done_at, b_done_at, wr_cnt, rd_cnt, wr_phases, b_wl_cnt;
  bit         err_seen, b_err_seen, prev_wr, b_prev_wr;
  logic [7:0] col_at_wr, ser_bits;
  int         wr_rows[$];
  int         b_wr_rows[$];

  sram_seq dut (
    .clk(clk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ser_in(ser_in),
    .row_sel(row_sel), .wl_wr_en(wl_wr_en), .wl_rd_en(wl_rd_en), .col_data(col_data),
    .sa_data(sa_data), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .done(done), .err(err)
  );

  // Non-power-of-two array sharing the same command stream.
  sram_seq #(.ROWS(12)) dut_b (
    .clk(clk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ser_in(ser_in),
    .row_sel(b_row_sel), .wl_wr_en(b_wl_wr_en), .wl_rd_en(b_wl_rd_en), .col_data(b_col_data),
    .sa_data(sa_data), .ser_out(b_ser_out), .ser_out_valid(b_ser_out_valid),
    .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t idleRec();
    exp_t r;
    r       = '0;
    r.ready = 1'b1;
    r.row   = m_row;
    r.col   = m_col;
    return r;
  endfunction

  // Expected per-cycle outputs for one accepted command, starting the cycle after acceptance.
  task automatic buildModel(input bit wr, input int addr, input int len,
                            input logic [31:0] words, input logic [7:0] sa);
    exp_t r;
    int   row;
    if (addr >= ROWS || len >= MAX_BURST) begin
      r    = idleRec();
      r.dn = 1'b1;
      r.er = 1'b1;
      exp_q.push_back(r);
      return;
    end
    row = addr;
    for (int w = 0; w <= len; w++) begin
      r       = '0;
      r.row   = row[3:0];
      r.col   = m_col;
      if (wr) begin
        for (int k = 0; k < COLS; k++) exp_q.push_back(r);
        m_col = words[w*8 +: 8];
        r.col = m_col;
        r.wr  = 1'b1;
        for (int k = 0; k < WR_CYC; k++) exp_q.push_back(r);
        r.wr  = 1'b0;
      end else begin
        r.rd = 1'b1;
        for (int k = 0; k < RD_SETTLE; k++) exp_q.push_back(r);
        r.rd = 1'b0;
        r.sv = 1'b1;
        for (int k = 0; k < COLS; k++) begin
          r.so = sa[k];
          exp_q.push_back(r);
        end
        r.sv = 1'b0;
        r.so = 1'b0;
      end
      r.dn = (w == len);
      exp_q.push_back(r);
      if (w < len) row = (row + 1) % ROWS;
    end
    m_row = row[3:0];
  endtask

  task automatic clearStats();
    since_acc  = 0;
    done_at    = -1;
    b_done_at  = -1;
    wr_cnt     = 0;
    rd_cnt     = 0;
    wr_phases  = 0;
    b_wl_cnt   = 0;
    err_seen   = 1'b0;
    b_err_seen = 1'b0;
    col_at_wr  = '0;
    ser_bits   = '0;
    wr_rows.delete();
    b_wr_rows.delete();
  endtask

  // Issue one command at a cycle boundary, feed its serial write data, and wait for it to drain.
  task automatic applyStimulus(input bit wr, input int addr, input int len,
                               input logic [31:0] words, input logic [7:0] sa, input bit hold);
    int guard;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr[3:0];
    cmd_len   = len[2:0];
    sa_data   = sa;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    clearStats();
    buildModel(wr, addr, len, words, sa);
    if (hold) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 4'd0;
      cmd_len   = 3'd0;
      repeat (5) begin @(posedge clk); #1; end
      cmd_valid = 1'b0;
    end
    if (wr && addr < ROWS && len < MAX_BURST) begin
      for (int w = 0; w <= len; w++) begin
        for (int k = 0; k < COLS; k++) begin
          ser_in = words[w*8 + k];
          @(posedge clk); #1;
        end
        ser_in = 1'b0;
        repeat (WR_CYC + 1) begin @(posedge clk); #1; end
      end
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle compare against the model, plus statistics for the literal checks.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = idleRec();
    since_acc++;
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(e.ready));
    checkOutput("wl_wr_en", 32'(wl_wr_en), 32'(e.wr));
    checkOutput("wl_rd_en", 32'(wl_rd_en), 32'(e.rd));
    checkOutput("ser_out_valid", 32'(ser_out_valid), 32'(e.sv));
    checkOutput("done", 32'(done), 32'(e.dn));
    checkOutput("err", 32'(err), 32'(e.er));
    checkOutput("row_sel", 32'(row_sel), 32'(e.row));
    checkOutput("col_data", 32'(col_data), 32'(e.col));
    if (e.sv) checkOutput("ser_out", 32'(ser_out), 32'(e.so));

    if (done && done_at < 0) done_at = since_acc;
    if (err) err_seen = 1'b1;
    if (wl_wr_en) wr_cnt++;
    if (wl_rd_en) rd_cnt++;
    if (wl_wr_en && !prev_wr) begin
      if (wr_phases == 0) col_at_wr = col_data;
      wr_phases++;
      wr_rows.push_back(int'(row_sel));
    end
    prev_wr = wl_wr_en;
    if (ser_out_valid) ser_bits = {ser_out, ser_bits[7:1]};

    if (b_done && b_done_at < 0) b_done_at = since_acc;
    if (b_err) b_err_seen = 1'b1;
    if (b_wl_wr_en || b_wl_rd_en) b_wl_cnt++;
    if (b_wl_wr_en && !b_prev_wr) b_wr_rows.push_back(int'(b_row_sel));
    b_prev_wr = b_wl_wr_en;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_rows[3];
    n_checks  = 0;
    n_errors  = 0;
    m_row     = '0;
    m_col     = '0;
    prev_wr   = 1'b0;
    b_prev_wr = 1'b0;
    clearStats();
    arst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    ser_in    = 1'b0;
    sa_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_wl_wr", 32'(wl_wr_en), 32'd0);
    checkOutput("rst_wl_rd", 32'(wl_rd_en), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_row", 32'(row_sel), 32'd0);
    checkOutput("rst_col", 32'(col_data), 32'd0);
    arst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single-word write, addr 3");
    applyStimulus(1'b1, 3, 0, 32'h0000004D, 8'h00, 1'b0);
    checkOutput("t1_col_entry", 32'(col_at_wr), 32'h4D);
    checkOutput("t1_wr_cycles", 32'(wr_cnt), 32'd2);
    checkOutput("t1_wr_row", 32'(wr_rows.size() > 0 ? wr_rows[0] : -1), 32'd3);
    checkOutput("t1_done_at", 32'(done_at), 32'd11);
    checkOutput("t1_rd_cycles", 32'(rd_cnt), 32'd0);

    $display("[TB] single-word read, addr 3, cmd_valid held during burst");
    applyStimulus(1'b0, 3, 0, 32'h0, 8'hA5, 1'b1);
    checkOutput("t2_rd_cycles", 32'(rd_cnt), 32'd3);
    checkOutput("t2_ser_bits", 32'(ser_bits), 32'hA5);
    checkOutput("t2_done_at", 32'(done_at), 32'd12);
    checkOutput("t2_wr_cycles", 32'(wr_cnt), 32'd0);

    $display("[TB] write burst, addr 15, len 2");
    applyStimulus(1'b1, 15, 2, 32'h00332211, 8'h00, 1'b0);
    exp_rows = '{15, 0, 1};
    checkOutput("t3_wr_phases", 32'(wr_phases), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_rows.size()) checkOutput("t3_row_seq", 32'(wr_rows[i]), 32'(exp_rows[i]));
    end
    checkOutput("t3_done_at", 32'(done_at), 32'd33);

    $display("[TB] invalid length 4");
    applyStimulus(1'b1, 2, 4, 32'h0, 8'h00, 1'b0);
    checkOutput("t4_done_at", 32'(done_at), 32'd1);
    checkOutput("t4_err", 32'(err_seen), 32'd1);
    checkOutput("t4_wl", 32'(wr_cnt + rd_cnt), 32'd0);

    $display("[TB] address 13 on the 12-row array");
    applyStimulus(1'b1, 13, 0, 32'h0000005A, 8'h00, 1'b0);
    checkOutput("t5_b_done_at", 32'(b_done_at), 32'd1);
    checkOutput("t5_b_err", 32'(b_err_seen), 32'd1);
    checkOutput("t5_b_wl", 32'(b_wl_cnt), 32'd0);
    checkOutput("t5_done_at", 32'(done_at), 32'd11);

    $display("[TB] wrap on the 12-row array, addr 11, len 1");
    applyStimulus(1'b1, 11, 1, 32'h0000C3F0, 8'h00, 1'b0);
    checkOutput("t6_b_rows_n", 32'(b_wr_rows.size()), 32'd2);
    checkOutput("t6_b_row1", 32'(b_wr_rows.size() > 1 ? b_wr_rows[1] : -1), 32'd0);
    checkOutput("t6_row1", 32'(wr_rows.size() > 1 ? wr_rows[1] : -1), 32'd12);

    $display("[TB] reset during second READ cycle");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd3;
    cmd_len   = 3'd0;
    sa_data   = 8'h99;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    clearStats();
    buildModel(1'b0, 3, 0, 32'h0, 8'h99);
    @(posedge clk); #2;
    arst = 1'b1;
    exp_q.delete();
    m_row = '0;
    m_col = '0;
    #1;
    checkOutput("t7_wl_rd_drop", 32'(wl_rd_en), 32'd0);
    checkOutput("t7_cmd_ready", 32'(cmd_ready), 32'd1);
    #1;
    arst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    checkOutput("t7_no_done", 32'(done_at), 32'hFFFFFFFF);

    $display("[TB] read after reset, addr 5");
    applyStimulus(1'b0, 5, 0, 32'h0, 8'h3C, 1'b0);
    checkOutput("t8_ser_bits", 32'(ser_bits), 32'h3C);
    checkOutput("t8_done_at", 32'(done_at), 32'd12);

    repeat (2) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
